// File: rtl/store_commit_buffer.sv
// Committed-store buffer: takes retiring stores from the speculative SQ head,
// drains them in order to the D-cache, and flags loads that alias a buffered store.
module store_commit_buffer #(
    parameter int unsigned CB_DEPTH = 4,
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              is_store,
    output logic                              store_accepted,
    input  logic                              sq_head_valid,
    input  logic [ADDR_W-1:0]                 sq_head_addr,
    input  logic [DATA_W-1:0]                 sq_head_data,
    input  logic [1:0]                        sq_head_size,
    output logic                              sq_pop,
    output logic                              dc_req_valid,
    output logic [ADDR_W-1:0]                 dc_req_addr,
    output logic [DATA_W-1:0]                 dc_req_data,
    output logic [1:0]                        dc_req_size,
    input  logic                              dc_req_ack,
    input  logic [ADDR_W-1:0]                 ld_addr,
    output logic                              ld_hit,
    output logic [$clog2(CB_DEPTH+1)-1:0]     cb_count,
    output logic                              cb_empty
);

    localparam int unsigned PTR_W = $clog2(CB_DEPTH);
    localparam int unsigned CNT_W = $clog2(CB_DEPTH + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [ADDR_W-1:0]   ent_addr [CB_DEPTH];
    logic [DATA_W-1:0]   ent_data [CB_DEPTH];
    logic [1:0]          ent_size [CB_DEPTH];
    logic [CB_DEPTH-1:0] ent_valid;
    logic [PTR_W-1:0]    head;
    logic [PTR_W-1:0]    tail;
    logic [CNT_W-1:0]    count;
    logic [CNT_W-1:0]    count_nxt;
    logic                enq;
    logic                deq;
    logic                unused_ld_lsb;

    // Full check uses only the registered count so the ack stays off the retire path.
    assign enq            = is_store & sq_head_valid & (count < CNT_W'(CB_DEPTH));
    assign deq            = (state == ISSUE) & dc_req_ack;
    assign count_nxt      = count + CNT_W'(enq) - CNT_W'(deq);
    assign store_accepted = enq;
    assign sq_pop         = enq;
    assign cb_count       = count;
    assign cb_empty       = (count == '0);
    assign unused_ld_lsb  = ^ld_addr[1:0];

    // Request fields come straight from the head entry while issuing.
    assign dc_req_addr = dc_req_valid ? ent_addr[head] : '0;
    assign dc_req_data = dc_req_valid ? ent_data[head] : '0;
    assign dc_req_size = dc_req_valid ? ent_size[head] : '0;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (count != '0) state_nxt = ISSUE;
            ISSUE:   if (deq) state_nxt = (count_nxt != '0) ? ISSUE : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Word-granular alias check; an entry being written this cycle is not yet valid.
    always_comb begin
        ld_hit = 1'b0;
        for (int i = 0; i < int'(CB_DEPTH); i++) begin
            if (ent_valid[i] && (ent_addr[i][ADDR_W-1:2] == ld_addr[ADDR_W-1:2])) begin
                ld_hit = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            dc_req_valid <= 1'b0;
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            ent_valid    <= '0;
            for (int i = 0; i < int'(CB_DEPTH); i++) begin
                ent_addr[i] <= '0;
                ent_data[i] <= '0;
                ent_size[i] <= '0;
            end
        end else begin
            state        <= state_nxt;
            dc_req_valid <= (state_nxt == ISSUE);
            count        <= count_nxt;
            if (enq) begin
                ent_addr[tail]  <= sq_head_addr;
                ent_data[tail]  <= sq_head_data;
                ent_size[tail]  <= sq_head_size;
                ent_valid[tail] <= 1'b1;
                tail            <= tail + PTR_W'(1);
            end
            if (deq) begin
                ent_valid[head] <= 1'b0;
                head            <= head + PTR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_store_commit_buffer.sv
// Directed bench for store_commit_buffer: accept, drain, full, wrap, alias, violation, reset.
module tb_store_commit_buffer;

    logic        clock;
    logic        reset;
    logic        is_store;
    logic        store_accepted;
    logic        sq_head_valid;
    logic [31:0] sq_head_addr;
    logic [31:0] sq_head_data;
    logic [1:0]  sq_head_size;
    logic        sq_pop;
    logic        dc_req_valid;
    logic [31:0] dc_req_addr;
    logic [31:0] dc_req_data;
    logic [1:0]  dc_req_size;
    logic        dc_req_ack;
    logic [31:0] ld_addr;
    logic        ld_hit;
    logic [2:0]  cb_count;
    logic        cb_empty;

    int n_checks = 0;
    int n_fail   = 0;
    int viol_cnt = 0;

    store_commit_buffer #(.CB_DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
        .clock          (clock),
        .reset          (reset),
        .is_store       (is_store),
        .store_accepted (store_accepted),
        .sq_head_valid  (sq_head_valid),
        .sq_head_addr   (sq_head_addr),
        .sq_head_data   (sq_head_data),
        .sq_head_size   (sq_head_size),
        .sq_pop         (sq_pop),
        .dc_req_valid   (dc_req_valid),
        .dc_req_addr    (dc_req_addr),
        .dc_req_data    (dc_req_data),
        .dc_req_size    (dc_req_size),
        .dc_req_ack     (dc_req_ack),
        .ld_addr        (ld_addr),
        .ld_hit         (ld_hit),
        .cb_count       (cb_count),
        .cb_empty       (cb_empty)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Retire-protocol monitor: a store without a resolved SQ head is illegal.
    always @(posedge clock) begin
        if (reset && is_store && !sq_head_valid) begin
            viol_cnt++;
            $display("protocol violation seen at %0t: is_store without sq_head_valid", $time);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic put(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
        is_store      = 1'b1;
        sq_head_valid = 1'b1;
        sq_head_addr  = a;
        sq_head_data  = d;
        sq_head_size  = s;
    endtask

    task automatic idle_in();
        is_store      = 1'b0;
        sq_head_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b0; is_store = 1'b0; sq_head_valid = 1'b0;
        sq_head_addr = '0; sq_head_data = '0; sq_head_size = '0;
        dc_req_ack = 1'b0; ld_addr = '0;
        tick(); tick();
        check("rst_valid", dc_req_valid, 0);
        check("rst_count", cb_count, 0);
        check("rst_empty", cb_empty, 1);
        check("rst_acc", store_accepted, 0);
        check("rst_ldhit", ld_hit, 0);
        check("rst_fields", {dc_req_addr, dc_req_data}, 0);
        check("rst_size", dc_req_size, 0);
        reset = 1'b1;
        tick();

        // Single store and stall
        put(32'h100, 32'hDEADBEEF, 2'd2);
        #1;
        check("s1_acc", store_accepted, 1);
        check("s1_pop", sq_pop, 1);
        tick();
        idle_in();
        check("s1_count", cb_count, 1);
        check("s1_valid_lat", dc_req_valid, 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            check("s1_valid", dc_req_valid, 1);
            check("s1_addr", dc_req_addr, 32'h100);
            check("s1_data", dc_req_data, 32'hDEADBEEF);
            check("s1_size", dc_req_size, 2);
            tick();
        end
        dc_req_ack = 1'b1;
        tick();
        dc_req_ack = 1'b0;
        check("s1_empty", cb_empty, 1);
        check("s1_valid_off", dc_req_valid, 0);

        // Fill to capacity, no full bypass
        for (int i = 0; i < 4; i++) begin
            put(32'h300 + 32'(4 * i), 32'h1000 + 32'(i), 2'd2);
            tick();
        end
        put(32'h310, 32'h1004, 2'd2);
        #1;
        check("full_count", cb_count, 4);
        check("full_acc", store_accepted, 0);
        check("full_head", dc_req_addr, 32'h300);
        dc_req_ack = 1'b1;
        #1;
        check("full_nobypass", store_accepted, 0);
        tick();
        dc_req_ack = 1'b0;
        #1;
        check("full_count3", cb_count, 3);
        check("full_acc_after", store_accepted, 1);
        tick();
        idle_in();
        check("full_count4", cb_count, 4);
        dc_req_ack = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            check("full_order_v", dc_req_valid, 1);
            check("full_order_d", dc_req_data, 32'h1000 + 32'(k));
            tick();
        end
        dc_req_ack = 1'b0;
        check("full_drained", cb_empty, 1);

        // Simultaneous enqueue/dequeue across wrap
        for (int i = 0; i < 2; i++) begin
            put(32'h400 + 32'(4 * i), 32'h2000 + 32'(i), 2'd1);
            tick();
        end
        idle_in();
        check("sim_count0", cb_count, 2);
        check("sim_valid0", dc_req_valid, 1);
        for (int k = 0; k < 10; k++) begin
            put(32'h408 + 32'(4 * k), 32'h2002 + 32'(k), 2'd1);
            dc_req_ack = 1'b1;
            #1;
            check("sim_data", dc_req_data, 32'h2000 + 32'(k));
            check("sim_acc", store_accepted, 1);
            tick();
            check("sim_count", cb_count, 2);
        end
        idle_in();
        check("sim_tail0", dc_req_data, 32'h200A);
        tick();
        check("sim_tail1", dc_req_data, 32'h200B);
        check("sim_tail1_sz", dc_req_size, 1);
        tick();
        dc_req_ack = 1'b0;
        check("sim_empty", cb_empty, 1);

        // Load alias
        put(32'h204, 32'h55, 2'd2);
        ld_addr = 32'h206;
        #1;
        check("ld_enq_excl", ld_hit, 0);
        tick();
        idle_in();
        check("ld_hit_206", ld_hit, 1);
        ld_addr = 32'h208;
        #1;
        check("ld_miss_208", ld_hit, 0);
        ld_addr = 32'h206;
        tick();
        check("ld_issue_v", dc_req_valid, 1);
        dc_req_ack = 1'b1;
        #1;
        check("ld_hit_ackcycle", ld_hit, 1);
        tick();
        dc_req_ack = 1'b0;
        check("ld_hit_retired", ld_hit, 0);

        // Protocol violation
        put(32'h500, 32'h77, 2'd0);
        tick();
        is_store = 1'b1;
        sq_head_valid = 1'b0;
        sq_head_data = 32'h88;
        #1;
        check("viol_acc", store_accepted, 0);
        check("viol_pop", sq_pop, 0);
        tick();
        idle_in();
        check("viol_count", cb_count, 1);
        check("viol_head", dc_req_data, 32'h77);

        // Async reset mid-drain
        put(32'h504, 32'h78, 2'd2);
        tick();
        put(32'h508, 32'h79, 2'd2);
        tick();
        idle_in();
        check("mid_count", cb_count, 3);
        check("mid_valid", dc_req_valid, 1);
        #2;
        reset = 1'b0;
        #1;
        check("ares_valid", dc_req_valid, 0);
        check("ares_count", cb_count, 0);
        check("ares_empty", cb_empty, 1);
        check("ares_data", dc_req_data, 0);
        tick();
        reset = 1'b1;
        tick();
        check("post_rst_valid", dc_req_valid, 0);
        put(32'h600, 32'h99, 2'd2);
        tick();
        idle_in();
        tick();
        check("post_rst_issue", dc_req_valid, 1);
        check("post_rst_data", dc_req_data, 32'h99);

        check("viol_flagged", 64'(viol_cnt), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/store_commit_buffer.md
Name: store_commit_buffer

Overview:
- Retire-side responder for the store half of the retire interface.
- When the ROB asserts is_store, the block accepts the store, pops the speculative store-queue head and holds it in a small committed-store FIFO.
- It drains committed stores in order to the D-cache over a valid/ack handshake.
- It also reports whether a load address aliases any committed but not yet written store, so load issue can stall.

Parameters:
- CB_DEPTH, 4, committed-buffer entries; must be a power of 2, at least 2.
- ADDR_W, 32, byte-address width.
- DATA_W, 32, store data width.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- is_store  in  1  retire: the oldest retiring instruction this cycle is a store.
- store_accepted  out  1  retire: store committed this cycle; the ROB may retire it.
- sq_head_valid  in  1  speculative SQ head holds a resolved store.
- sq_head_addr  in  ADDR_W  head store byte address.
- sq_head_data  in  DATA_W  head store data, right-aligned.
- sq_head_size  in  2  0 = byte, 1 = half, 2 = word.
- sq_pop  out  1  dequeue the speculative SQ head; identical to store_accepted.
- dc_req_valid  out  1  D-cache write request.
- dc_req_addr  out  ADDR_W  request address.
- dc_req_data  out  DATA_W  request data.
- dc_req_size  out  2  request size.
- dc_req_ack  in  1  D-cache accepts the request this cycle.
- ld_addr  in  ADDR_W  load address to check.
- ld_hit  out  1  a valid buffered store matches ld_addr on bits [ADDR_W-1:2].
- cb_count  out  $clog2(CB_DEPTH+1)  occupied entries.
- cb_empty  out  1  cb_count == 0; used for halt/fence drain.

Behaviour:
- Reset (asynchronous on reset low), all immediate:
  - head/tail pointers = 0, cb_count = 0, all entry valid bits = 0.
  - FSM = IDLE, dc_req_valid = 0, store_accepted = 0, ld_hit = 0, cb_empty = 1.
  - dc_req_addr, dc_req_data and dc_req_size = 0.
- Accept (combinational):
  - store_accepted = sq_pop = is_store & sq_head_valid & (cb_count < CB_DEPTH).
  - No full-bypass: a dc_req_ack in the same cycle does not allow accept when full. This keeps dc_req_ack off the retire path.
- Enqueue on store_accepted:
  - Write the sq_head_* fields into entry[tail] at the clock edge and set its valid bit.
  - tail advances modulo CB_DEPTH.
- is_store with sq_head_valid = 0 is a protocol violation:
  - store_accepted = 0 and the buffer is unchanged.
  - The bench flags it with an assertion.
- Drain FSM:
  - IDLE: dc_req_valid = 0. If cb_count > 0, go to ISSUE next cycle.
  - ISSUE: dc_req_valid = 1 and dc_req_* = entry[head], driven from the head entry registers.
  - While in ISSUE without ack, the fields stay stable.
  - On dc_req_ack: clear valid[head] and advance head modulo CB_DEPTH.
  - After an ack, stay in ISSUE if entries remain after this cycle's enqueue/dequeue; otherwise go to IDLE.
  - Back-to-back drains are allowed: one store per ack cycle.
- Latency: a store accepted at edge t produces dc_req_valid at t+1 at the earliest when the buffer was empty. The IDLE->ISSUE transition takes one cycle.
- Simultaneous enqueue and dequeue: cb_count is unchanged; both pointers advance.
- Wrap-around: pointers are $clog2(CB_DEPTH) bits, and full/empty is decided by cb_count only.
- ld_hit (combinational):
  - OR over valid entries of (entry.addr[ADDR_W-1:2] == ld_addr[ADDR_W-1:2]).
  - Size is ignored (conservative word match).
  - The entry being enqueued this cycle is excluded; the speculative SQ still covers it this cycle.
  - An entry acked this cycle still counts until the edge.
- Ordering: strict FIFO; the D-cache sees stores in retire order.
- Reset mid-operation: buffered stores are discarded; an in-flight request is dropped.

Test Plan:
- Single store: reset, then is_store=1, sq_head_valid=1, addr=0x100, data=0xDEADBEEF, size=2 for one cycle.
  - Required: store_accepted=1 that cycle; cb_count=1 next cycle; dc_req_valid=1 with addr 0x100 and data 0xDEADBEEF one cycle later.
  - Hold dc_req_ack=0 for 3 cycles: fields stable. Pulse ack: cb_empty=1 next cycle and dc_req_valid=0.
- Full: enqueue 4 stores with dc_req_ack held 0, then assert is_store again.
  - Required: store_accepted=0 and cb_count=4.
  - Ack once: the 5th store is accepted the cycle after; order on the D-cache is preserved.
- Simultaneous enqueue and dequeue: cb_count=2, accept a store and ack in the same cycle.
  - Required: cb_count stays 2; head and tail both advance.
  - Continue for 10 cycles across wrap-around: data order is exact.
- Load alias: buffer holds addr 0x204.
  - ld_addr=0x206 -> ld_hit=1; ld_addr=0x208 -> ld_hit=0.
  - After the ack of 0x204 retires it: ld_hit=0 for 0x206 next cycle.
- Protocol violation: is_store=1 with sq_head_valid=0.
  - Required: store_accepted=0, sq_pop=0, cb_count unchanged, assertion fires.
- Asynchronous reset mid-drain: cb_count=3 and dc_req_valid=1; drop reset between edges.
  - Required: dc_req_valid=0 and cb_count=0 immediately; FSM = IDLE after reset release.
